// File: rtl/alu_operand_stage_pkg.sv
// Shared core types for the operand stage: RV32I opcode/format enums and the
// forwarding-source record.
package alu_operand_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA,
        FENCE, ECALL, EBREAK
    } rv32i_base_instr;

    typedef enum logic [2:0] {
        R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
    } rv32i_base_instr_type;

    typedef struct packed {
        logic            valid;
        logic            pending;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] data;
    } fwd_src_t;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Priority forwarding select for one source operand; index 0 is the youngest
// producer and wins over every older one.
module alu_fwd_mux #(
    parameter int NUM_FWD    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic [NUM_FWD-1:0]                 fwd_valid,
    input  logic [NUM_FWD-1:0]                 fwd_pending,
    input  logic [NUM_FWD-1:0][4:0]            fwd_rd_addr,
    input  logic [NUM_FWD-1:0][DATA_WIDTH-1:0] fwd_data,
    input  logic [4:0]                         rs_addr,
    input  logic [DATA_WIDTH-1:0]              rs_data,
    output logic [DATA_WIDTH-1:0]              data,
    output logic                               pending
);

    logic [NUM_FWD-1:0] hit;

    // x0 is hard-wired zero, so it never matches a producer.
    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_hit
            assign hit[gi] = fwd_valid[gi] && (fwd_rd_addr[gi] == rs_addr) && (rs_addr != 5'd0);
        end
    endgenerate

    // Walk oldest to youngest so the lowest matching index is what remains.
    always_comb begin
        data    = rs_data;
        pending = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (hit[i]) begin
                data    = fwd_data[i];
                pending = fwd_pending[i];
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// One-entry registered operand stage: resolves forwarded sources, selects ALU
// operands, stalls on pending producers and counts stall cycles.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_FWD    = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ADDR_WIDTH-1:0]              in_pc,
    input  rv32i_base_instr                    in_opcode,
    input  rv32i_base_instr_type               in_instr_type,
    input  logic [4:0]                         in_rs1_addr,
    input  logic [4:0]                         in_rs2_addr,
    input  logic [DATA_WIDTH-1:0]              in_rs1_data,
    input  logic [DATA_WIDTH-1:0]              in_rs2_data,
    input  logic [DATA_WIDTH-1:0]              in_imm,
    input  logic [NUM_FWD-1:0]                 fwd_valid,
    input  logic [NUM_FWD-1:0]                 fwd_pending,
    input  logic [NUM_FWD-1:0][4:0]            fwd_rd_addr,
    input  logic [NUM_FWD-1:0][DATA_WIDTH-1:0] fwd_data,
    input  logic                               flush,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_src_a,
    output logic [DATA_WIDTH-1:0]              out_src_b,
    output logic [DATA_WIDTH-1:0]              out_store_data,
    output logic [ADDR_WIDTH-1:0]              out_pc,
    output rv32i_base_instr                    out_opcode,
    output rv32i_base_instr_type               out_instr_type,
    output logic                               hazard_stall,
    output logic [31:0]                        stall_count
);

    logic [DATA_WIDTH-1:0] rs1_res, rs2_res, pc_ext, src_a_sel, src_b_sel;
    logic                  rs1_pend, rs2_pend, accept;

    logic                  out_valid_q, out_valid_d;
    logic [31:0]           stall_count_q, stall_count_d;
    logic [DATA_WIDTH-1:0] src_a_q, src_a_d, src_b_q, src_b_d, store_q, store_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    rv32i_base_instr       opcode_q, opcode_d;
    rv32i_base_instr_type  itype_q, itype_d;

    alu_fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_WIDTH(DATA_WIDTH)) u_fwd_rs1 (
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data),
        .rs_addr(in_rs1_addr), .rs_data(in_rs1_data),
        .data(rs1_res), .pending(rs1_pend)
    );

    alu_fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_WIDTH(DATA_WIDTH)) u_fwd_rs2 (
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data),
        .rs_addr(in_rs2_addr), .rs_data(in_rs2_data),
        .data(rs2_res), .pending(rs2_pend)
    );

    assign hazard_stall = in_valid && (rs1_pend || rs2_pend);
    assign in_ready     = (!out_valid_q || out_ready) && !hazard_stall && !flush;
    assign accept       = in_valid && in_ready;

    always_comb begin
        pc_ext = DATA_WIDTH'(in_pc);
        case (in_opcode)
            AUIPC, JAL, JALR: src_a_sel = pc_ext;
            LUI:              src_a_sel = '0;
            default:          src_a_sel = rs1_res;
        endcase
        case (in_instr_type)
            I_TYPE, S_TYPE, U_TYPE, J_TYPE: src_b_sel = in_imm;
            default:                        src_b_sel = rs2_res;
        endcase
    end

    // Payload only loads on accept, so a held entry is frozen until it drains.
    always_comb begin
        out_valid_d   = out_valid_q;
        stall_count_d = stall_count_q;
        src_a_d       = src_a_q;
        src_b_d       = src_b_q;
        store_d       = store_q;
        pc_d          = pc_q;
        opcode_d      = opcode_q;
        itype_d       = itype_q;
        if (flush)           out_valid_d = 1'b0;
        else if (accept)     out_valid_d = 1'b1;
        else if (out_ready)  out_valid_d = 1'b0;
        if (accept) begin
            src_a_d  = src_a_sel;
            src_b_d  = src_b_sel;
            store_d  = rs2_res;
            pc_d     = in_pc;
            opcode_d = in_opcode;
            itype_d  = in_instr_type;
        end
        if (hazard_stall && (stall_count_q != 32'hFFFF_FFFF))
            stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            stall_count_q <= '0;
            src_a_q       <= '0;
            src_b_q       <= '0;
            store_q       <= '0;
            pc_q          <= '0;
            opcode_q      <= LUI;
            itype_q       <= R_TYPE;
        end else begin
            out_valid_q   <= out_valid_d;
            stall_count_q <= stall_count_d;
            src_a_q       <= src_a_d;
            src_b_q       <= src_b_d;
            store_q       <= store_d;
            pc_q          <= pc_d;
            opcode_q      <= opcode_d;
            itype_q       <= itype_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign stall_count    = stall_count_q;
    assign out_src_a      = src_a_q;
    assign out_src_b      = src_b_q;
    assign out_store_data = store_q;
    assign out_pc         = pc_q;
    assign out_opcode     = opcode_q;
    assign out_instr_type = itype_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: handshake, forwarding priority, hazards,
// operand selection, back-pressure, flush and asynchronous reset.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NF = 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       in_valid, in_ready;
    logic [AW-1:0]              in_pc;
    rv32i_base_instr            in_opcode;
    rv32i_base_instr_type       in_instr_type;
    logic [4:0]                 in_rs1_addr, in_rs2_addr;
    logic [DW-1:0]              in_rs1_data, in_rs2_data, in_imm;
    logic [NF-1:0]              fwd_valid, fwd_pending;
    logic [NF-1:0][4:0]         fwd_rd_addr;
    logic [NF-1:0][DW-1:0]      fwd_data;
    logic                       flush;
    logic                       out_valid, out_ready;
    logic [DW-1:0]              out_src_a, out_src_b, out_store_data;
    logic [AW-1:0]              out_pc;
    rv32i_base_instr            out_opcode;
    rv32i_base_instr_type       out_instr_type;
    logic                       hazard_stall;
    logic [31:0]                stall_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_FWD(NF)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_opcode(in_opcode), .in_instr_type(in_instr_type),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_src_a(out_src_a), .out_src_b(out_src_b), .out_store_data(out_store_data),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_instr_type(out_instr_type),
        .hazard_stall(hazard_stall), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) begin
            $display("[TB] ok   %s = %0h", tag, obs);
        end else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input rv32i_base_instr op, input rv32i_base_instr_type ty,
                             input logic [AW-1:0] pc, input logic [4:0] r1a, input logic [DW-1:0] r1d,
                             input logic [4:0] r2a, input logic [DW-1:0] r2d, input logic [DW-1:0] imm);
        in_opcode = op; in_instr_type = ty; in_pc = pc;
        in_rs1_addr = r1a; in_rs1_data = r1d;
        in_rs2_addr = r2a; in_rs2_data = r2d;
        in_imm = imm;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        fwd_valid = '0; fwd_pending = '0; fwd_rd_addr = '0; fwd_data = '0;
        set_instr(ADD, R_TYPE, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0);
        repeat (2) tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_stall_count", stall_count, 32'd0);
        check("rst_src_a", out_src_a, 32'd0);
        check("rst_opcode", out_opcode, LUI);
        check("rst_itype", out_instr_type, R_TYPE);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // ADD x3,x1,x2 with no forwarding
        set_instr(ADD, R_TYPE, 32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0);
        in_valid = 1'b1;
        tick();
        check("add_valid", out_valid, 1'b1);
        check("add_src_a", out_src_a, 32'd5);
        check("add_src_b", out_src_b, 32'd7);
        check("add_store", out_store_data, 32'd7);
        check("add_pc", out_pc, 32'h100);

        // Forward priority: youngest wins, older used alone, x0 never forwarded
        fwd_valid = 2'b11; fwd_rd_addr[0] = 5'd4; fwd_rd_addr[1] = 5'd4;
        fwd_data[0] = 32'hAA; fwd_data[1] = 32'hBB;
        set_instr(ADD, R_TYPE, 32'h104, 5'd4, 32'h11, 5'd5, 32'h22, 32'h0);
        tick();
        check("fwd_prio_a", out_src_a, 32'hAA);
        check("fwd_prio_b", out_src_b, 32'h22);
        fwd_valid = 2'b10;
        tick();
        check("fwd_older_a", out_src_a, 32'hBB);
        fwd_valid = 2'b01; fwd_rd_addr[0] = 5'd0;
        set_instr(ADD, R_TYPE, 32'h108, 5'd0, 32'h33, 5'd5, 32'h22, 32'h0);
        tick();
        check("fwd_x0_a", out_src_a, 32'h33);

        // Pending producer on rs2 stalls three cycles
        fwd_valid = 2'b01; fwd_rd_addr[0] = 5'd2; fwd_pending = 2'b01; fwd_data[0] = 32'h77;
        set_instr(ADD, R_TYPE, 32'h200, 5'd1, 32'h10, 5'd2, 32'h99, 32'h0);
        #1;
        check("haz_stall", hazard_stall, 1'b1);
        check("haz_in_ready", in_ready, 1'b0);
        tick();
        check("haz_stall_c1", hazard_stall, 1'b1);
        check("haz_drained", out_valid, 1'b0);
        tick();
        tick();
        check("haz_in_ready_c3", in_ready, 1'b0);
        fwd_pending = 2'b00;
        #1;
        check("haz_count", stall_count, 32'd3);
        check("haz_release_ready", in_ready, 1'b1);
        tick();
        check("haz_acc_valid", out_valid, 1'b1);
        check("haz_acc_b", out_src_b, 32'h77);
        check("haz_acc_store", out_store_data, 32'h77);
        check("haz_acc_a", out_src_a, 32'h10);
        check("haz_count_hold", stall_count, 32'd3);

        // Younger non-pending match masks older pending one
        fwd_valid = 2'b11; fwd_rd_addr[1] = 5'd2; fwd_pending = 2'b10;
        #1;
        check("mask_stall", hazard_stall, 1'b0);
        fwd_pending = 2'b01;
        #1;
        check("young_pend_stall", hazard_stall, 1'b1);
        fwd_valid = 2'b00; fwd_pending = 2'b00;

        // Operand selection by opcode and format
        set_instr(AUIPC, U_TYPE, 32'h1000, 5'd1, 32'h55, 5'd2, 32'h66, 32'h2000);
        tick();
        check("auipc_a", out_src_a, 32'h1000);
        check("auipc_b", out_src_b, 32'h2000);
        set_instr(LUI, U_TYPE, 32'h1004, 5'd1, 32'h55, 5'd2, 32'h66, 32'h3000);
        tick();
        check("lui_a", out_src_a, 32'h0);
        check("lui_b", out_src_b, 32'h3000);
        set_instr(SW, S_TYPE, 32'h1008, 5'd1, 32'h100, 5'd2, 32'h42, 32'h8);
        tick();
        check("sw_a", out_src_a, 32'h100);
        check("sw_b", out_src_b, 32'h8);
        check("sw_store", out_store_data, 32'h42);
        set_instr(JAL, J_TYPE, 32'h100C, 5'd1, 32'h55, 5'd2, 32'h66, 32'h40);
        tick();
        check("jal_a", out_src_a, 32'h100C);
        check("jal_b", out_src_b, 32'h40);

        // Back-pressure holds outputs, then back-to-back accept without bubble
        set_instr(ADD, R_TYPE, 32'h2000, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0);
        tick();
        out_ready = 1'b0;
        set_instr(SUB, R_TYPE, 32'h2004, 5'd1, 32'h123, 5'd2, 32'h456, 32'h0);
        #1;
        check("bp_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_a", out_src_a, 32'd5);
            check("bp_hold_pc", out_pc, 32'h2000);
        end
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", in_ready, 1'b1);
        tick();
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_a", out_src_a, 32'h123);
        check("b2b_b", out_src_b, 32'h456);
        check("b2b_opcode", out_opcode, SUB);

        // Flush while full overrides the incoming instruction
        out_ready = 1'b0; flush = 1'b1;
        set_instr(ADD, R_TYPE, 32'h3000, 5'd1, 32'h9, 5'd2, 32'h9, 32'h0);
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        tick();
        check("flush_valid", out_valid, 1'b0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush_nothing", out_valid, 1'b0);

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b1; in_valid = 1'b1;
        set_instr(ADD, R_TYPE, 32'h4000, 5'd3, 32'h1, 5'd4, 32'h2, 32'h0);
        tick();
        out_ready = 1'b0;
        fwd_valid = 2'b01; fwd_rd_addr[0] = 5'd1; fwd_pending = 2'b01;
        set_instr(ADD, R_TYPE, 32'h4004, 5'd1, 32'h1, 5'd4, 32'h2, 32'h0);
        tick();
        tick();
        check("pre_rst_count", stall_count, 32'd5);
        check("pre_rst_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_count", stall_count, 32'd0);
        check("arst_src_a", out_src_a, 32'd0);
        in_valid = 1'b0; fwd_valid = 2'b00; fwd_pending = 2'b00; out_ready = 1'b1;
        tick();
        rst_n = 1'b1; in_valid = 1'b1;
        set_instr(ADD, R_TYPE, 32'h5000, 5'd1, 32'hC, 5'd2, 32'hD, 32'h0);
        tick();
        check("post_rst_valid", out_valid, 1'b1);
        check("post_rst_a", out_src_a, 32'hC);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
